// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the sequential 32x32 shift-add multiplier:
//   - mul_state_e : controller state encoding (IDLE, RUN, FIX, DONE)
//   - MUL_W       : operand width
//   - MUL_PW      : product width (2 * MUL_W)
//   - MUL_ITER    : number of shift-add iterations per product
//   - MUL_CNT_W   : width of the iteration counter
// FIX is only ever reached when the design is built with MUL_SIGNED_EN.
// -----------------------------------------------------------------------------
package mul_pkg;

    localparam int MUL_W     = 32;
    localparam int MUL_PW    = 2 * MUL_W;
    localparam int MUL_ITER  = MUL_W;
    localparam int MUL_CNT_W = $clog2(MUL_ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mul_state_e;

endpackage : mul_pkg

// File: rtl/mul_shift_add_step.sv
// -----------------------------------------------------------------------------
// mul_shift_add_step
// One combinational shift-add iteration of the multiplier.
//   mark_i  : add enable for this step (LSB of the product register)
//   mcand_i : multiplicand (WIDTH bits)
//   prod_i  : current product register (2*WIDTH bits)
//   prod_o  : next product register (2*WIDTH bits)
// The upper half plus the (optional) multiplicand is formed WIDTH+1 bits wide
// so the carry-out lands in the MSB of the shifted result instead of being lost.
// -----------------------------------------------------------------------------
module mul_shift_add_step #(
    parameter int WIDTH = 32
) (
    input  logic                 mark_i,
    input  logic [WIDTH-1:0]     mcand_i,
    input  logic [2*WIDTH-1:0]   prod_i,
    output logic [2*WIDTH-1:0]   prod_o
);

    logic [WIDTH:0] addend_s;
    logic [WIDTH:0] sum_s;

    // Form the WIDTH+1-bit upper sum and shift the whole register right by one.
    always_comb begin
        addend_s = {(WIDTH+1){1'b0}};
        if (mark_i) begin
            addend_s = {1'b0, mcand_i};
        end else begin
            addend_s = {(WIDTH+1){1'b0}};
        end
        sum_s  = {1'b0, prod_i[2*WIDTH-1:WIDTH]} + addend_s;
        prod_o = {sum_s, prod_i[WIDTH-1:1]};
    end

endmodule : mul_shift_add_step

// File: rtl/mul_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mul_seq_ctrl
// Sequential controller for the WIDTH x WIDTH shift-add multiplier. Accepts an
// operand pair when ready, performs one shift-add step per clock for WIDTH
// cycles, and presents the 2*WIDTH-bit product with a one-cycle done pulse.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   request, sampled only while ready is high
//   a          in   multiplicand, captured on accepted start
//   b          in   multiplier, captured on accepted start
//   mul_signed in   two's-complement mode (only with MUL_SIGNED_EN)
//   ready      out  high in IDLE and DONE
//   busy       out  high in RUN (and FIX)
//   done       out  one-cycle pulse when product becomes valid
//   product    out  product register; intermediate values while busy
//
// Configuration macro: MUL_SIGNED_EN
//   Defined   : adds mul_signed and the FIX state. Signed operands are reduced
//               to magnitudes at accept, the sign of the result is latched,
//               and FIX negates the product when needed (latency WIDTH+1).
//   Undefined : unsigned only, latency WIDTH.
// -----------------------------------------------------------------------------
module mul_seq_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef MUL_SIGNED_EN
    input  logic                 mul_signed,
`endif
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mul_state_e             state_q, state_d;
    logic [WIDTH-1:0]       mcand_q, mcand_d;
    logic [2*WIDTH-1:0]     prod_q, prod_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [2*WIDTH-1:0]     step_prod_s;

`ifdef MUL_SIGNED_EN
    logic                   sgn_q, sgn_d;
    logic                   neg_q, neg_d;

    // Two's-complement magnitude; the most-negative value maps to 2^(WIDTH-1)
    // read as unsigned, which is exactly its magnitude.
    function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (v[WIDTH-1]) begin
            r = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Two's-complement negation of the full product.
    function automatic logic [2*WIDTH-1:0] neg_prod(input logic [2*WIDTH-1:0] v);
        return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction
`endif

    mul_shift_add_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .mark_i  (prod_q[0]),
        .mcand_i (mcand_q),
        .prod_i  (prod_q),
        .prod_o  (step_prod_s)
    );

    // Next-state, datapath-load and output-register decode.
    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        cnt_d   = cnt_q;
`ifdef MUL_SIGNED_EN
        sgn_d   = sgn_q;
        neg_d   = neg_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
`ifdef MUL_SIGNED_EN
                    if (mul_signed) begin
                        mcand_d = mag_of(a);
                        prod_d  = {{WIDTH{1'b0}}, mag_of(b)};
                        neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
                    end else begin
                        mcand_d = a;
                        prod_d  = {{WIDTH{1'b0}}, b};
                        neg_d   = 1'b0;
                    end
                    sgn_d   = mul_signed;
`else
                    mcand_d = a;
                    prod_d  = {{WIDTH{1'b0}}, b};
`endif
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = RUN;
                end else begin
                    state_d = state_q;
                end
            end

            RUN: begin
                prod_d = step_prod_s;
                cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_LAST) begin
`ifdef MUL_SIGNED_EN
                    if (sgn_q) begin
                        state_d = FIX;
                    end else begin
                        state_d = DONE;
                    end
`else
                    state_d = DONE;
`endif
                end else begin
                    state_d = RUN;
                end
            end

`ifdef MUL_SIGNED_EN
            FIX: begin
                if (neg_q) begin
                    prod_d = neg_prod(prod_q);
                end else begin
                    prod_d = prod_q;
                end
                state_d = DONE;
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered from the next state so they line up
        // with the state register.
        ready_d = (state_d == IDLE) || (state_d == DONE);
        busy_d  = (state_d == RUN)  || (state_d == FIX);
        done_d  = (state_d == DONE) && (state_q != DONE);
    end

    // State, datapath and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mcand_q <= {WIDTH{1'b0}};
            prod_q  <= {(2*WIDTH){1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef MUL_SIGNED_EN
    // Sign-mode and result-sign registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sgn_q <= 1'b0;
            neg_q <= 1'b0;
        end else begin
            sgn_q <= sgn_d;
            neg_q <= neg_d;
        end
    end
`endif

    assign ready   = ready_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod_q;

endmodule : mul_seq_ctrl

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequential controller for the 32×32 shift-add integer multiplier. It accepts a multiplicand and a multiplier and holds the 64-bit product register. It iterates one shift-add step per clock for 32 cycles and presents the 64-bit product with a done pulse. It sits directly upstream of the per-step shift-add unit: it generates that unit's `mark`, multiplicand and product-register inputs, and registers its result back each cycle.

## Interface
- `WIDTH`, 32: operand width; product is 2·WIDTH bits; iteration count = WIDTH.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `ready`=1.
- `a`  in  WIDTH  multiplicand, captured on accepted `start`.
- `b`  in  WIDTH  multiplier, captured on accepted `start`.
- `mul_signed`  in  1  two's-complement mode select; present only with `MUL_SIGNED_EN`.
- `ready`  out  1  high in IDLE and DONE.
- `busy`  out  1  high in RUN (and FIX).
- `done`  out  1  one-cycle pulse when `product` becomes valid.
- `product`  out  2·WIDTH  result; held until the next accepted `start`.

## Operation
- States: IDLE, RUN, FIX (only with macro), DONE.
- IDLE/DONE + `start`=1: load `mcand`<=`a`, `prod`<={WIDTH'b0, `b`}, `cnt`<=0; go RUN.
- RUN, each cycle:
  - `mark`=`prod[0]`.
  - Upper sum = `prod[2W-1:W]` + (`mark` ? `mcand` : 0), computed WIDTH+1 bits wide.
  - `prod` <= {carry, upper sum, `prod[W-1:1]`}.
  - `cnt`++.
- The carry-out of the add is shifted into bit 2W-1; it is never dropped.
- RUN with `cnt`=WIDTH-1: go DONE (unsigned) or FIX (signed).
- DONE: `done`=1 for that first cycle only. The state remains DONE (`ready`=1) until `start`.
- `start` while RUN/FIX: ignored, with no effect on state or operands.
- `start` in the same cycle DONE is entered: not possible, because `ready`=0 in the last RUN cycle.
- `product` output = `prod` register. It is undefined-free during RUN: it shows intermediate values, and consumers use `done`.
- Reset:
  - `rst` forces IDLE, `prod`=0, `mcand`=0, `cnt`=0, `done`=0, `busy`=0, `ready`=1, `product`=0.
  - Mid-operation reset aborts with no done pulse.

## Timing
- Accept edge E0. RUN covers edges E1..E32 (32 steps).
- Unsigned: `done` is high in the cycle after E32, i.e. the result appears 32 cycles after the accept edge.
- Signed: one extra FIX edge, so latency is 33.
- Back-to-back: a `start` in the `done` cycle is accepted. Throughput is one product per 33 (34 signed) cycles.
- `cnt` width = $clog2(WIDTH); it wraps only via reload.

## Configuration
- `MUL_SIGNED_EN` defined: adds the `mul_signed` port and the FIX state.
  - When `mul_signed`=1 at accept, `a` and `b` are replaced by their magnitudes. `neg` = `a[W-1]`^`b[W-1]` is latched.
  - FIX: if `neg`, `prod` <= ~`prod`+1.
  - The magnitude of the most-negative value (0x80000000) is treated as unsigned 2^31; the result is correct.
- Undefined: unsigned only; no port, no FIX state, 32-cycle latency.

## Structure
- A shared package `mul_pkg` holds:
  - the state enum (IDLE, RUN, FIX, DONE);
  - `MUL_W`=32;
  - `MUL_PW`=64;
  - the iteration-count localparam.
- One sub-module, `mul_shift_add_step`, is combinational: it takes `mark`, `mcand`, `prod` and returns the next `prod` with carry preserved.
- The controller owns all registers.

## Test plan
- `a`=3, `b`=5 -> `done` 32 cycles after accept, `product`=0x000000000000000F.
- `a`=`b`=0xFFFFFFFF -> `product`=0xFFFFFFFE00000001 (carry-into-MSB path).
- `a`=0x12345678, `b`=0 -> 0. Then `start` with `a`=0, `b`=0xDEADBEEF in the `done` cycle -> accepted, 0 again, 32 cycles later.
- `start` pulsed at cycle 10 of RUN with different operands -> ignored; the first result is unchanged and `done` occurs once.
- `rst` at cycle 15 of RUN -> next cycle IDLE, `product`=0, `ready`=1, no `done`; a subsequent 7×9 -> 63.
- With `MUL_SIGNED_EN`:
  - `mul_signed`=1, `a`=-3, `b`=7 -> 0xFFFFFFFFFFFFFFEB after 33 cycles.
  - `a`=`b`=0x80000000 -> 0x4000000000000000.
